// File: rtl/systolic_skew_feeder_pkg.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder_pkg
//
// Shared definitions for the activation skew feeder that sits in front of the
// processing-element array.
//   - feed_state_t   : job-control FSM encoding (IDLE / FEED / DRAIN)
//   - DEFAULT_*      : default geometry; DEFAULT_DATA_W matches the PE
//                      systolic_input width so the feeder plugs in directly.
//   - drain_width()  : width needed to hold a drain count of 'rows'.
// -----------------------------------------------------------------------------
package systolic_skew_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } feed_state_t;

    localparam int DEFAULT_ROWS   = 4;
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CNT_W  = 8;

    // Bits needed to represent the value 'rows' (always at least 1).
    function automatic int drain_width(input int rows);
        int w;
        w = $clog2(rows + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : systolic_skew_feeder_pkg

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
//
// Fixed-depth shift chain carrying a {valid, data} pair. Shifts every cycle
// with no enable; a bubble (valid=0) travels down the chain exactly like a
// real sample, which is what keeps the wavefront aligned across lanes.
//
// Parameters:
//   DEPTH  number of register stages (>= 1)
//   WIDTH  data width
//
// Ports:
//   clk        clock
//   reset      synchronous active-high clear of every stage
//   in_valid   valid bit entering stage 0
//   in_data    data entering stage 0
//   out_valid  valid bit leaving the last stage
//   out_data   data leaving the last stage
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // Bit WIDTH of each stage is the valid flag, the rest is data.
    logic [WIDTH:0] stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= {in_valid, in_data};
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign out_valid = stage_reg[DEPTH-1][WIDTH];
    assign out_data  = stage_reg[DEPTH-1][WIDTH-1:0];

endmodule : skew_delay_line

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Upstream stage of the PE array. Accepts one activation vector per cycle
// over valid/ready and applies a triangular skew so that row r reaches its PE
// r cycles after row 0 (diagonal wavefront). Runs one start-triggered job of
// num_vecs vectors, then pulses done once the last row has been presented.
//
// Parameters:
//   ROWS    array rows / skew lanes (>= 1)
//   DATA_W  activation width (PE systolic_input width)
//   CNT_W   width of num_vecs
//
// Ports:
//   clk       clock
//   reset     synchronous active-high reset; abandons a job without done
//   start     one-cycle job start, honoured only when idle
//   num_vecs  vectors in the job, sampled with start
//   in_valid  activation vector valid
//   in_ready  feeder can accept a vector (FEED only)
//   in_vec    activation vector, row r at [r*DATA_W +: DATA_W]
//   sys_data  per-row data to PE systolic_input, same packing as in_vec
//   sys_en    per-row load enable to PE systolic_ctr
//   busy      job in progress
//   done      one-cycle pulse after the job has fully drained
//
// Timing: a vector accepted at edge k appears on row r after edge k+1+r
// (r+1 lane stages plus the output register). With the last acceptance at
// edge k, done rises and busy falls at edge k+ROWS+1.
// -----------------------------------------------------------------------------
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int ROWS   = DEFAULT_ROWS,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_vecs,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_vec,
    output logic [ROWS*DATA_W-1:0] sys_data,
    output logic [ROWS-1:0]        sys_en,
    output logic                   busy,
    output logic                   done
);

    localparam int DRAIN_W = drain_width(ROWS);

    // ------------------------------------------------------------------
    // Job-control FSM
    // ------------------------------------------------------------------
    feed_state_t         state_reg;
    logic [CNT_W-1:0]    remaining_reg;
    logic [DRAIN_W-1:0]  drain_cnt_reg;
    logic                in_ready_reg;
    logic                busy_reg;
    logic                done_reg;
    // Set on the edge that finishes a job (or takes a zero-length start);
    // done is raised from it one edge later.
    logic                done_pending_reg;

    logic                accept;

    assign accept = in_valid && in_ready_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            remaining_reg    <= '0;
            drain_cnt_reg    <= '0;
            in_ready_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            done_pending_reg <= 1'b0;
        end else begin
            done_reg         <= done_pending_reg;
            done_pending_reg <= 1'b0;
            if (done_pending_reg) begin
                busy_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    // A pending done still belongs to the previous job, so a
                    // start landing on that cycle is treated as "while busy".
                    if (start && !done_pending_reg) begin
                        if (num_vecs != '0) begin
                            state_reg     <= ST_FEED;
                            remaining_reg <= num_vecs;
                            in_ready_reg  <= 1'b1;
                            busy_reg      <= 1'b1;
                        end else begin
                            done_pending_reg <= 1'b1;
                        end
                    end
                end

                ST_FEED: begin
                    if (accept) begin
                        if (remaining_reg == CNT_W'(1)) begin
                            state_reg     <= ST_DRAIN;
                            drain_cnt_reg <= DRAIN_W'(ROWS);
                            in_ready_reg  <= 1'b0;
                        end
                        remaining_reg <= remaining_reg - CNT_W'(1);
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt_reg == DRAIN_W'(1)) begin
                        state_reg        <= ST_IDLE;
                        done_pending_reg <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
                    end
                end

                default: begin
                    state_reg    <= ST_IDLE;
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Skew lanes: lane r has r+1 stages. Non-accepted cycles inject a
    // zero-filled bubble so invalid slots reach the PE as data 0.
    // ------------------------------------------------------------------
    logic [ROWS-1:0]        lane_valid;
    logic [ROWS*DATA_W-1:0] lane_data;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
            logic [DATA_W-1:0] lane_in_data;

            assign lane_in_data = accept ? in_vec[gi*DATA_W +: DATA_W] : '0;

            skew_delay_line #(
                .DEPTH (gi + 1),
                .WIDTH (DATA_W)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (accept),
                .in_data   (lane_in_data),
                .out_valid (lane_valid[gi]),
                .out_data  (lane_data[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register towards the PE array
    // ------------------------------------------------------------------
    logic [ROWS-1:0]        sys_en_reg;
    logic [ROWS*DATA_W-1:0] sys_data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sys_en_reg   <= '0;
            sys_data_reg <= '0;
        end else begin
            sys_en_reg   <= lane_valid;
            sys_data_reg <= lane_data;
        end
    end

    assign sys_en   = sys_en_reg;
    assign sys_data = sys_data_reg;
    assign in_ready = in_ready_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule : systolic_skew_feeder

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
//
// Directed bench for systolic_skew_feeder (ROWS=4, DATA_W=8). Each job drives
// a slot pattern of valid/bubble cycles; for vector v, row r carries byte
// seed + 16*v + r, expected on sys_en[r]/sys_data row r after edge
// (acceptance edge + 1 + r). done is expected after edge last+ROWS+1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_systolic_skew_feeder;

    localparam int ROWS   = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [CNT_W-1:0]       num_vecs;
    logic                   in_valid;
    logic                   in_ready;
    logic [ROWS*DATA_W-1:0] in_vec;
    logic [ROWS*DATA_W-1:0] sys_data;
    logic [ROWS-1:0]        sys_en;
    logic                   busy;
    logic                   done;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    systolic_skew_feeder #(
        .ROWS   (ROWS),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_vecs (num_vecs),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .sys_data (sys_data),
        .sys_en   (sys_en),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROWS*DATA_W-1:0] mk_vec(input int v, input logic [7:0] seed);
        logic [ROWS*DATA_W-1:0] x;
        x = '0;
        for (int r = 0; r < ROWS; r++) begin
            x[r*DATA_W +: DATA_W] = 8'(int'(seed) + v*16 + r);
        end
        return x;
    endfunction

    // Compare all outputs after relative edge e of a job.
    task automatic check_edge(input string name, input int e, input int a, input int n,
                              input int acc[16], input logic [7:0] seed);
        logic [ROWS-1:0]        en_e;
        logic [ROWS*DATA_W-1:0] d_e;
        logic                   lk;
        int                     lastv;
        en_e = '0;
        d_e  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int v = 0; v < a; v++) begin
                if (acc[v] + 1 + r == e) begin
                    en_e[r] = 1'b1;
                    d_e[r*DATA_W +: DATA_W] = 8'(int'(seed) + v*16 + r);
                end
            end
        end
        lk    = (a == n);
        lastv = lk ? acc[n-1] : 0;
        check($sformatf("%s_e%0d_en", name, e), 64'(sys_en), 64'(en_e));
        check($sformatf("%s_e%0d_data", name, e), 64'(sys_data), 64'(d_e));
        check($sformatf("%s_e%0d_ready", name, e), 64'(in_ready), 64'(a < n));
        check($sformatf("%s_e%0d_busy", name, e), 64'(busy),
              64'(!(lk && e >= lastv + ROWS + 1)));
        check($sformatf("%s_e%0d_done", name, e), 64'(done),
              64'(lk && e == lastv + ROWS + 1));
        $display("job %s edge %0d: sys_en=%b sys_data=%h busy=%0b done=%0b",
                 name, e, sys_en, sys_data, busy, done);
    endtask

    // Run one job. gap_mask bit s=1 makes slot s a bubble. A start pulse with
    // num_vecs=7 is injected at restart_edge (-1: none) and must be ignored.
    task automatic run_job(input string name, input int n, input logic [7:0] seed,
                           input logic [15:0] gap_mask, input int restart_edge);
        int acc[16];
        int a;
        int e;
        int s;
        int last;
        a = 0;
        e = 0;
        s = 0;
        for (int i = 0; i < 16; i++) acc[i] = 0;
        start    = 1'b1;
        num_vecs = CNT_W'(n);
        in_valid = 1'b0;
        step();
        start = 1'b0;
        check_edge(name, e, a, n, acc, seed);
        while (a < n && s < 16) begin
            in_valid = !gap_mask[s];
            in_vec   = mk_vec(a, seed);
            start    = (e + 1 == restart_edge);
            num_vecs = start ? CNT_W'(7) : CNT_W'(n);
            step();
            e++;
            start = 1'b0;
            if (in_valid) begin
                acc[a] = e;
                a++;
            end
            in_valid = 1'b0;
            s++;
            check_edge(name, e, a, n, acc, seed);
        end
        check({name, "_all_accepted"}, 64'(a), 64'(n));
        last = acc[n-1];
        while (e < last + ROWS + 2) begin
            start    = (e + 1 == restart_edge);
            num_vecs = start ? CNT_W'(7) : CNT_W'(n);
            step();
            e++;
            start = 1'b0;
            check_edge(name, e, a, n, acc, seed);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        num_vecs = '0;
        in_valid = 1'b0;
        in_vec   = '0;
        repeat (3) step();
        check("rst_sys_en", 64'(sys_en), 64'(0));
        check("rst_sys_data", 64'(sys_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(0));
        reset = 1'b0;
        step();

        // Single vector, rows {01,02,03,04}
        run_job("single", 1, 8'h01, 16'h0000, -1);
        // Back-to-back, rows {1x,2x,3x}
        run_job("b2b", 3, 8'h10, 16'h0000, -1);
        // Bubble between two vectors
        run_job("bubble", 2, 8'h40, 16'h0002, -1);
        // Start while busy: during FEED, then during DRAIN
        run_job("restart_feed", 3, 8'h70, 16'h0004, 2);
        run_job("restart_drain", 2, 8'hA0, 16'h0000, 5);

        // Zero-length job: done one cycle after the start edge, nothing else
        start    = 1'b1;
        num_vecs = '0;
        step();
        start = 1'b0;
        check("zero_e0_done", 64'(done), 64'(0));
        check("zero_e0_busy", 64'(busy), 64'(0));
        check("zero_e0_ready", 64'(in_ready), 64'(0));
        step();
        check("zero_e1_done", 64'(done), 64'(1));
        check("zero_e1_busy", 64'(busy), 64'(0));
        check("zero_e1_ready", 64'(in_ready), 64'(0));
        check("zero_e1_en", 64'(sys_en), 64'(0));
        $display("zero job: done=%0b busy=%0b", done, busy);
        step();
        check("zero_e2_done", 64'(done), 64'(0));

        // Reset mid-job after 2 of 5 vectors
        start    = 1'b1;
        num_vecs = CNT_W'(5);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_vec   = mk_vec(0, 8'h55);
        step();
        in_vec   = mk_vec(1, 8'h55);
        step();
        reset = 1'b1;
        step();
        check("midrst_en", 64'(sys_en), 64'(0));
        check("midrst_data", 64'(sys_data), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_ready", 64'(in_ready), 64'(0));
        $display("mid-job reset: sys_en=%b busy=%0b done=%0b", sys_en, busy, done);
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < ROWS + 3; i++) begin
            step();
            check($sformatf("postrst_%0d_done", i), 64'(done), 64'(0));
            check($sformatf("postrst_%0d_en", i), 64'(sys_en), 64'(0));
        end
        run_job("after_rst", 2, 8'hC0, 16'h0000, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule : tb_systolic_skew_feeder
